// File: rtl/dial_pkg.sv
// rtl/dial_pkg.sv - shared types, constants and helpers for the dial positioner
// Contents: FSM state encoding, one-hot coil phases, direction codes,
//           K/M derivation (whole and fractional steps per dial position).
package dial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_STEP = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam logic [3:0] PH_0 = 4'b0001;
    localparam logic [3:0] PH_1 = 4'b0010;
    localparam logic [3:0] PH_2 = 4'b0100;
    localparam logic [3:0] PH_3 = 4'b1000;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // Whole motor steps per dial position.
    function automatic int calc_k(input int steps_rev, input int num_pos);
        return steps_rev / num_pos;
    endfunction

    // Leftover steps per revolution, spread over positions by remainder tracking.
    function automatic int calc_m(input int steps_rev, input int num_pos);
        return steps_rev % num_pos;
    endfunction

    function automatic logic [3:0] phase_onehot(input logic [1:0] idx);
        logic [3:0] ph;
        case (idx)
            2'd0:    ph = PH_0;
            2'd1:    ph = PH_1;
            2'd2:    ph = PH_2;
            default: ph = PH_3;
        endcase
        return ph;
    endfunction

endpackage

// File: rtl/dial_step_gen.sv
// rtl/dial_step_gen.sv - step prescaler and 4-phase coil sequencer
// Ports: clk, reset_n (async active-low), en (count/step enable), dir (DIR_FWD/DIR_REV),
//        step_tick (one-cycle strobe on the cycle a step is taken), phase (one-hot coil).
module dial_step_gen
    import dial_pkg::*;
#(
    parameter int CLK_DIV = 50000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       dir,
    output logic       step_tick,
    output logic [3:0] phase
);

    localparam int            CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] presc_q;
    logic [1:0]    ph_q;

    // Prescaler restarts from zero on every entry, so the first step lands
    // exactly CLK_DIV cycles after the enable rises.
    assign step_tick = en && (presc_q == DIV_LAST);
    assign phase     = phase_onehot(ph_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q <= '0;
            ph_q    <= 2'd0;
        end else if (!en) begin
            presc_q <= '0;
        end else if (step_tick) begin
            presc_q <= '0;
            ph_q    <= (dir == DIR_FWD) ? ph_q + 2'd1 : ph_q - 2'd1;
        end else begin
            presc_q <= presc_q + 1'b1;
        end
    end

endmodule

// File: rtl/dial_positioner.sv
// rtl/dial_positioner.sv - shortest-path stepper dial positioner with exact fractional stepping
// Ports: clk, reset_n (async active-low), req/target_pos (move request), abort (stop at
//        next position boundary), cmd_zero (redefine current position as 0 when idle),
//        ready, done (pulse), err (pulse, bad target), cur_pos, motor_drv (one-hot coils).
module dial_positioner
    import dial_pkg::*;
#(
    parameter int NUM_POS   = 32,
    parameter int POS_W     = 5,
    parameter int STEPS_REV = 200,
    parameter int CLK_DIV   = 50000,
    parameter int HOLD_EN   = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req,
    input  logic [POS_W-1:0] target_pos,
    input  logic             abort,
    input  logic             cmd_zero,
    output logic             ready,
    output logic             done,
    output logic             err,
    output logic [POS_W-1:0] cur_pos,
    output logic [3:0]       motor_drv
);

    localparam int RW    = $clog2(NUM_POS);
    localparam int K     = calc_k(STEPS_REV, NUM_POS);
    localparam int M     = calc_m(STEPS_REV, NUM_POS);
    localparam int SEG_W = $clog2(K + 2);

    localparam logic [RW:0]        NP_R     = (RW + 1)'(NUM_POS);
    localparam logic [RW:0]        M_R      = (RW + 1)'(M);
    localparam logic [POS_W:0]     NP_P     = (POS_W + 1)'(NUM_POS);
    localparam logic [POS_W:0]     HALF_P   = (POS_W + 1)'(NUM_POS / 2);
    localparam logic [POS_W-1:0]   POS_LAST = POS_W'(NUM_POS - 1);
    localparam logic [SEG_W-1:0]   SEG_K    = SEG_W'(K);
    localparam logic [SEG_W-1:0]   SEG_K1   = SEG_W'(K + 1);
    localparam logic [SEG_W-1:0]   SEG_ONE  = SEG_W'(1);

    // rem = (cur_pos*STEPS_REV) % NUM_POS; a segment gets the extra step whenever
    // the fractional part carries over a whole step.
    function automatic logic [SEG_W-1:0] seg_len(input logic [RW-1:0] r, input logic d);
        logic [RW:0] s;
        s = {1'b0, r} + M_R;
        if (d == DIR_FWD) return (s >= NP_R) ? SEG_K1 : SEG_K;
        else              return ({1'b0, r} < M_R) ? SEG_K1 : SEG_K;
    endfunction

    function automatic logic [RW-1:0] rem_next(input logic [RW-1:0] r, input logic d);
        logic [RW:0] t;
        if (d == DIR_FWD) begin
            t = {1'b0, r} + M_R;
            if (t >= NP_R) t = t - NP_R;
        end else if ({1'b0, r} < M_R) begin
            t = {1'b0, r} + NP_R - M_R;
        end else begin
            t = {1'b0, r} - M_R;
        end
        return RW'(t);
    endfunction

    state_t           state_q;
    logic [POS_W-1:0] cur_pos_q, target_q;
    logic [RW-1:0]    rem_q;
    logic [SEG_W-1:0] seg_q;
    logic             dir_q, abort_q, ready_q, done_q, err_q;

    logic [POS_W:0]   dist_raw, dist_d;
    logic             dir_d;
    logic [POS_W-1:0] pos_d;
    logic [RW-1:0]    rem_d;
    logic             step_tick;
    logic [3:0]       phase;
    logic             tgt_ok;

    assign tgt_ok = ({1'b0, target_pos} < NP_P);

    always_comb begin
        dist_raw = {1'b0, target_q} + NP_P - {1'b0, cur_pos_q};
        dist_d   = (dist_raw >= NP_P) ? dist_raw - NP_P : dist_raw;
        // Exactly half way round goes forward.
        dir_d    = (dist_d <= HALF_P) ? DIR_FWD : DIR_REV;
        pos_d    = cur_pos_q;
        if (dir_q == DIR_FWD) pos_d = (cur_pos_q == POS_LAST) ? '0 : cur_pos_q + 1'b1;
        else                  pos_d = (cur_pos_q == '0) ? POS_LAST : cur_pos_q - 1'b1;
        rem_d    = rem_next(rem_q, dir_q);
    end

    dial_step_gen #(.CLK_DIV(CLK_DIV)) u_step_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .en        (state_q == ST_STEP),
        .dir       (dir_q),
        .step_tick (step_tick),
        .phase     (phase)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cur_pos_q <= '0;
            target_q  <= '0;
            rem_q     <= '0;
            seg_q     <= '0;
            dir_q     <= DIR_FWD;
            abort_q   <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (req) begin
                        if (tgt_ok) begin
                            target_q <= target_pos;
                            state_q  <= ST_CALC;
                            ready_q  <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (cmd_zero) begin
                        cur_pos_q <= '0;
                        rem_q     <= '0;
                    end
                end
                ST_CALC: begin
                    abort_q <= abort;
                    if (dist_d == '0) begin
                        state_q <= ST_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        dir_q   <= dir_d;
                        seg_q   <= seg_len(rem_q, dir_d);
                        state_q <= ST_STEP;
                    end
                end
                ST_STEP: begin
                    if (abort) abort_q <= 1'b1;
                    if (step_tick) begin
                        if (seg_q == SEG_ONE) begin
                            cur_pos_q <= pos_d;
                            rem_q     <= rem_d;
                            // Abort only takes effect on a position boundary.
                            if (pos_d == target_q || abort_q || abort) begin
                                state_q <= ST_DONE;
                                done_q  <= 1'b1;
                            end else begin
                                seg_q <= seg_len(rem_d, dir_q);
                            end
                        end else begin
                            seg_q <= seg_q - 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    done_q  <= 1'b0;
                    ready_q <= 1'b1;
                    abort_q <= 1'b0;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cur_pos   = cur_pos_q;
    assign motor_drv = (state_q == ST_STEP || HOLD_EN != 0) ? phase : 4'b0000;

endmodule

// File: tb/tb_dial_positioner.sv
// tb/tb_dial_positioner.sv - self-checking bench for dial_positioner
module tb_dial_positioner;

    localparam int NP = 32;
    localparam int PW = 6;
    localparam int SR = 200;
    localparam int CD = 4;

    logic          clk = 1'b0;
    logic          reset_n, req, abort, cmd_zero;
    logic [PW-1:0] target_pos;
    logic          ready, done, err;
    logic [PW-1:0] cur_pos;
    logic [3:0]    motor_drv;

    int n_tests = 0;
    int n_fail  = 0;
    int m_pos   = 0;
    int m_ph    = 0;

    always #5 clk = ~clk;

    dial_positioner #(
        .NUM_POS(NP), .POS_W(PW), .STEPS_REV(SR), .CLK_DIV(CD), .HOLD_EN(0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .target_pos(target_pos),
        .abort(abort), .cmd_zero(cmd_zero), .ready(ready), .done(done),
        .err(err), .cur_pos(cur_pos), .motor_drv(motor_drv)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Motor steps between dial positions q and q+1 (either direction).
    function automatic int seg(input int q);
        return ((q + 1) * SR) / NP - (q * SR) / NP;
    endfunction

    function automatic logic [3:0] oh(input int p);
        logic [3:0] v;
        v = 4'b0001 << p;
        return v;
    endfunction

    task automatic move(input int tgt, input int abort_at, input bit noise, input bit with_zero);
        int d, fwd, npos, steps, k, s, q, cyc, nz, trans, bad;
        bit fin;
        logic [3:0] prev, rot;
        d    = (tgt - m_pos + NP) % NP;
        fwd  = (d <= NP / 2) ? 1 : 0;
        npos = fwd ? d : NP - d;
        s    = abort_at / CD;
        steps = 0; k = 0; q = m_pos;
        while (k < npos) begin
            if (fwd) begin
                steps += seg(q);
                q = (q + 1) % NP;
            end else begin
                q = (q + NP - 1) % NP;
                steps += seg(q);
            end
            k++;
            if (abort_at > 0 && steps >= s) break;
        end
        req = 1'b1; target_pos = PW'(tgt); cmd_zero = with_zero;
        cyc = 0; nz = 0; trans = 0; bad = 0; fin = 1'b0; prev = 4'b0;
        while (!fin && cyc < 1000) begin
            @(negedge clk);
            cyc++;
            req = 1'b0; cmd_zero = 1'b0; abort = 1'b0;
            if (motor_drv != 4'b0) begin
                nz++;
                if (nz == 1) chk("start_phase", motor_drv, oh(m_ph));
                else if (motor_drv != prev) begin
                    trans++;
                    rot = fwd ? {prev[2:0], prev[3]} : {prev[0], prev[3:1]};
                    if (motor_drv != rot) bad++;
                end
                if (nz == abort_at) abort = 1'b1;
                if (noise && $urandom_range(0, 3) == 0) begin
                    req = 1'b1;
                    target_pos = PW'($urandom_range(0, NP - 1));
                    cmd_zero = 1'($urandom_range(0, 1));
                end
            end
            prev = motor_drv;
            if (done) fin = 1'b1;
        end
        chk("done_seen", fin, 1);
        chk("latency", cyc, (steps == 0) ? 2 : 2 + steps * CD);
        chk("final_pos", cur_pos, q);
        chk("motor_cycles", nz, steps * CD);
        chk("transitions", trans, (steps > 0) ? steps - 1 : 0);
        chk("bad_dir", bad, 0);
        m_pos = q;
        m_ph  = (((m_ph + (fwd ? steps : -steps)) % 4) + 4) % 4;
        @(negedge clk);
        chk("ready_after", ready, 1);
        chk("done_single", done, 0);
    endtask

    task automatic err_req(input int tgt);
        req = 1'b1; target_pos = PW'(tgt);
        @(negedge clk);
        req = 1'b0;
        chk("err_pulse", err, 1);
        chk("err_ready", ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("err_quiet", {err, done, ready, motor_drv}, {1'b0, 1'b0, 1'b1, 4'b0});
        end
        chk("err_pos", cur_pos, m_pos);
    endtask

    task automatic zero_idle();
        cmd_zero = 1'b1;
        @(negedge clk);
        cmd_zero = 1'b0;
        chk("zero_pos", cur_pos, 0);
        m_pos = 0;
    endtask

    initial begin
        reset_n = 1'b0; req = 1'b0; abort = 1'b0; cmd_zero = 1'b0; target_pos = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", ready, 1);
        chk("rst_flags", {done, err}, 0);
        chk("rst_pos", cur_pos, 0);
        chk("rst_motor", motor_drv, 0);
        reset_n = 1'b1;
        @(negedge clk);

        move(1, 0, 0, 0);
        move(3, 0, 0, 0);
        move(31, 0, 0, 0);
        move(0, 0, 0, 0);
        move(16, 0, 0, 0);
        move(0, 0, 0, 0);
        move(5, 0, 0, 0);
        move(0, 0, 0, 0);
        move(0, 0, 0, 0);
        err_req(40);
        err_req(32);
        move(7, 0, 1, 0);
        zero_idle();
        move(9, 0, 0, 0);
        move(4, 0, 0, 1);
        move(0, 0, 0, 0);
        move(10, $urandom_range(5, 200), 0, 0);

        for (int i = 0; i < 25; i++) begin
            if ($urandom_range(0, 7) == 0) zero_idle();
            move($urandom_range(0, NP - 1),
                 ($urandom_range(0, 3) == 0) ? $urandom_range(1, 250) : 0,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0));
        end

        // Reset in the middle of stepping.
        move(0, 0, 0, 0);
        req = 1'b1; target_pos = PW'(16);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            req = 1'b0;
        end
        chk("pre_reset_moving", motor_drv != 4'b0, 1);
        chk("pre_reset_pos", cur_pos, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_motor", motor_drv, 0);
        chk("async_rst_pos", cur_pos, 0);
        chk("async_rst_ready", ready, 1);
        @(negedge clk);
        reset_n = 1'b1;
        m_pos = 0; m_ph = 0;
        @(negedge clk);
        move(1, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
